fp_add_arbiter: RTL
===================

# fp_add_arbiter

Shares one `floatingPointAdder` instance between `N_REQ` requesters. The block arbitrates pending requests and drives the selected requester's operands onto the adder. It sequences the adder's `start`/`done` handshake and returns the 32-bit sum to the granted requester with a one-cycle valid pulse. It sits between the requester-side clients and the adder's top-level ports.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `W`, 32: operand/result width (IEEE-754 single); fixed at 32 for the current adder.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `N_REQ`: per-requester level request; held with operands until own `res_valid`.
- `a_in` in `N_REQ*W`: flattened operand A, slice i = requester i.
- `b_in` in `N_REQ*W`: flattened operand B.
- `gnt` out `N_REQ`: one-hot, high while requester owns the adder.
- `res` out `W`: sum; valid only with `res_valid`, held until next result.
- `res_valid` out `N_REQ`: one-hot, one-cycle pulse to the owner.
- `busy` out 1: high in any state other than IDLE.
- `add_a`, `add_b` out `W`: adder operands, registered, stable from START through WAIT.
- `add_start` out 1: one-cycle start pulse to the adder.
- `add_done` in 1: adder completion level.
- `add_ans` in `W`: adder result.

## Operation
- States: IDLE, START, WAIT, RESP (2-bit encoding).
- IDLE, `req`≠0:
  - Pick winner `idx` by the arbitration rule (see Configuration).
  - Register `a_in[idx]`/`b_in[idx]` into `add_a`/`add_b`.
  - Set `gnt[idx]`, go to START.
- IDLE, `req`=0: stay; outputs idle.
- START: `add_start`=1 for exactly this cycle; go to WAIT.
- WAIT:
  - Sample `done_q` = registered `add_done`.
  - Capture only on the rising edge (`add_done`=1 and `done_q`=0): `res` ← `add_ans`, go to RESP.
  - Edge detection makes a stale `done` level from the previous operation harmless.
- RESP:
  - `res_valid[idx]`=1 for one cycle; `gnt` clears at the end of the cycle.
  - Update the arbitration pointer; go to IDLE.
- Requester dropping `req` while granted is ignored: the operation completes and `res_valid` still pulses. The requester discards the result.
- `req` changes on non-granted lines are sampled only in IDLE.
- Operands are latched once; later changes to `a_in`/`b_in` do not affect the running operation.

## Timing
- Reset values:
  - State IDLE.
  - `gnt`, `res_valid`, `add_start`, `busy`, `done_q` = 0.
  - `add_a`, `add_b`, `res` = 0.
  - Pointer = 0.
- Reset mid-operation aborts immediately and returns to IDLE. The adder must be reset by the same `rst`; the bench ties both to it.
- Latency: `req` seen in IDLE at cycle t → `add_start` at t+1 → WAIT from t+2.
  - `add_done` rise at cycle d → `res_valid` at d+1.
  - Total = adder latency + 3 cycles.
- Back-to-back: IDLE is re-entered the cycle after RESP.
  - A requester that keeps `req` high after its `res_valid` is treated as a new request.
  - Requesters drop `req` on the edge where they see `res_valid`.
- Minimum issue interval between adder operations: 4 cycles plus the adder latency.

## Configuration
- `FP_ADD_ARB_RR_EN` defined: round-robin.
  - Search starts at pointer p, upward with wrap.
  - After RESP, p ← `idx`+1 mod `N_REQ`.
- Not defined: fixed priority; lowest index wins; no pointer register is built.

## Test plan
- Single request: requester 0, A=0x3FC00000 (1.5), B=0x40200000 (2.5).
  - Expect `gnt`=0001, one `add_start` pulse, then `res`=0x40800000 with `res_valid`=0001 one cycle after the `add_done` rise.
- Contention, RR build: `req`=1111 held continuously, each slot A=B=0x3F800000.
  - Expect grants in order 0,1,2,3,0 and every `res`=0x40000000.
  - Non-RR build: requester 0 is granted repeatedly.
- Stale done: `add_done` left high from the previous op on entry to WAIT.
  - Expect no capture until `add_done` falls and rises again.
- Request withdrawn: requester 2 drops `req` during WAIT.
  - Expect `res_valid`=0100 still issued; the next arbitration ignores requester 2.
- Reset mid-WAIT: assert `rst` one cycle.
  - Expect all outputs 0 and state IDLE next cycle.
  - After release with `req`=0010, expect a fresh grant to requester 1.
- Operand change after grant: alter `a_in[0]` during WAIT.
  - Expect `add_a` unchanged and the sum computed from the latched value.

Source files
------------

// File: rtl/fp_add_arbiter_if.sv
// fp_add_arbiter_if: requester-side and adder-side signals of the shared adder arbiter
interface fp_add_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W = 32
);
  logic [N_REQ-1:0] req, gnt, res_valid;
  logic [N_REQ*W-1:0] a_in, b_in;
  logic [W-1:0] res, add_a, add_b, add_ans;
  logic busy, add_start, add_done;
  modport master (
    input req, a_in, b_in, add_done, add_ans,
    output gnt, res, res_valid, busy, add_a, add_b, add_start
  );
  modport slave (
    output req, a_in, b_in, add_done, add_ans,
    input gnt, res, res_valid, busy, add_a, add_b, add_start
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one adder among N_REQ requesters; define FP_ADD_ARB_RR_EN for round-robin, else fixed priority
module fp_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int W = 32
) (
  input logic clk,
  input logic rst,
  fp_add_arbiter_if.master bus
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  state_t state, state_n;
  logic done_q, found, done_rise;
  logic [IW-1:0] win;
  logic [N_REQ-1:0] gnt_q;
  logic [W-1:0] a_sel, b_sel, add_a_q, add_b_q, res_q;
`ifdef FP_ADD_ARB_RR_EN
  logic [IW-1:0] ptr, idx;
  // first pending request at or above the pointer, wrapping around
  always_comb begin
    int j;
    j = 0;
    found = 1'b0;
    win = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!found && bus.req[j]) begin
        found = 1'b1;
        win = IW'(j);
      end
    end
  end
  // remember the winner and advance the pointer past it once served
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      idx <= '0;
    end else begin
      if (state == IDLE && found) idx <= win;
      if (state == RESP) ptr <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end
`else
  // lowest pending index wins
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        found = 1'b1;
        win = IW'(k);
      end
    end
  end
`endif
  // operand mux for the current winner
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IW'(i)) begin
        a_sel = bus.a_in[i*W +: W];
        b_sel = bus.b_in[i*W +: W];
      end
    end
  end
  // a done level already high when WAIT starts is not an edge, so stale completions are ignored
  assign done_rise = bus.add_done && !done_q;
  // next-state logic
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (found ? START : IDLE) :
              (state == START) ? WAIT :
              (state == WAIT) ? (done_rise ? RESP : WAIT) : IDLE;
  end
  // state, grant, latched operands, done history and result
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt_q <= '0;
      done_q <= 1'b0;
      add_a_q <= '0;
      add_b_q <= '0;
      res_q <= '0;
    end else begin
      state <= state_n;
      done_q <= bus.add_done;
      if (state == IDLE && found) begin
        gnt_q <= N_REQ'(1) << win;
        add_a_q <= a_sel;
        add_b_q <= b_sel;
      end else if (state == RESP) begin
        gnt_q <= '0;
      end
      if (state == WAIT && done_rise) res_q <= bus.add_ans;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.add_a = add_a_q;
  assign bus.add_b = add_b_q;
  assign bus.res = res_q;
  assign bus.add_start = state == START;
  assign bus.busy = state != IDLE;
  assign bus.res_valid = (state == RESP) ? gnt_q : '0;
endmodule
